// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states,
// control/status register bit positions and the divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int CTRL_TXEN    = 0;
  localparam int CTRL_PAREN   = 1;
  localparam int CTRL_PARODD  = 2;
  localparam int CTRL_TWOSTOP = 3;
  localparam int CTRL_FLUSH   = 4;
  localparam int CTRL_IRQEN   = 5;
  localparam int CTRL_OVFCLR  = 6;
  localparam int DIV_LSB      = 16;
  localparam int DIV_W        = 16;

  // Only persistent fields are stored; strobe bits never reach the register.
  localparam logic [31:0] CTRL_WR_MASK = 32'hFFFF_002F;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LVL_LSB = 8;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only when
// a pop happens on the same edge.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Memory-mapped UART transmitter: control/status registers, TX FIFO and a
// frame FSM that sends queued bytes back-to-back with per-frame latched format.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int DIV_RESET    = 5208,
  parameter int ADDR_SEL_BIT = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] rd_data_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 sel, ctrl_wr, data_wr, flush, ovf_clr, tx_en;
  logic [31:0]          ctrl_q, ctrl_d, status;
  logic                 ovf_q, ovf_d, irq_q, irq_d;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [LVL_W-1:0]     fifo_level;
  logic [DATA_BITS-1:0] fifo_rdata, shift_q;
  tx_state_e            state_q;
  logic [DIV_W-1:0]     cnt_q, div_q, new_div;
  logic [2:0]           bit_q;
  logic                 par_en_q, par_bit_q, two_stop_q, stop2_q, tx_q;
  logic                 bit_done, start_frame;
  logic                 unused_addr;

  assign unused_addr = ^addr_i;
  assign sel         = addr_i[ADDR_SEL_BIT];
  assign ctrl_wr     = we_i & ~sel;
  assign data_wr     = we_i & sel;
  assign flush       = ctrl_wr & data_i[CTRL_FLUSH];
  assign ovf_clr     = ctrl_wr & data_i[CTRL_OVFCLR];
  assign tx_en       = ctrl_q[CTRL_TXEN];
  assign new_div     = eff_div(ctrl_q[DIV_LSB +: DIV_W]);
  assign bit_done    = (cnt_q == '0);

  // A new frame starts from IDLE or straight out of the final stop period.
  assign start_frame = tx_en & ~fifo_empty &
                       ((state_q == IDLE) |
                        ((state_q == STOP) & bit_done & (~two_stop_q | stop2_q)));
  assign fifo_pop    = start_frame;

  uart_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .push_i (data_wr),
    .pop_i  (fifo_pop),
    .flush_i(flush),
    .wdata_i(data_i[DATA_BITS-1:0]),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  always_comb begin
    ctrl_d = ctrl_wr ? (data_i & CTRL_WR_MASK) : ctrl_q;
    ovf_d  = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    else if (data_wr & fifo_full & ~fifo_pop) ovf_d = 1'b1;
    irq_d  = ctrl_q[CTRL_IRQEN] & fifo_empty & (state_q == IDLE);
  end

  always_comb begin
    status                            = '0;
    status[STAT_BUSY]                 = (state_q != IDLE);
    status[STAT_FULL]                 = fifo_full;
    status[STAT_EMPTY]                = fifo_empty;
    status[STAT_OVF]                  = ovf_q;
    status[STAT_LVL_LSB +: LVL_W]     = fifo_level;
  end

  assign rd_data_o = sel ? status : ctrl_q;
  assign tx_o      = tx_q;
  assign irq_o     = irq_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q <= 32'(DIV_RESET) << DIV_LSB;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      ovf_q  <= ovf_d;
      irq_q  <= irq_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      cnt_q      <= '0;
      div_q      <= DIV_W'(1);
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
    end else if (start_frame) begin
      state_q    <= START;
      tx_q       <= 1'b0;
      div_q      <= new_div;
      cnt_q      <= new_div - DIV_W'(1);
      par_en_q   <= ctrl_q[CTRL_PAREN];
      two_stop_q <= ctrl_q[CTRL_TWOSTOP];
      stop2_q    <= 1'b0;
    end else begin
      cnt_q <= bit_done ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
      case (state_q)
        IDLE: tx_q <= 1'b1;
        START: if (bit_done) begin
          state_q <= DATA;
          tx_q    <= shift_q[0];
          bit_q   <= '0;
        end
        DATA: if (bit_done) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
            state_q <= par_en_q ? PARITY : STOP;
            tx_q    <= par_en_q ? par_bit_q : 1'b1;
          end else begin
            bit_q <= bit_q + 3'd1;
            tx_q  <= shift_q[1];
          end
        end
        PARITY: if (bit_done) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: if (bit_done) begin
          if (two_stop_q && !stop2_q) stop2_q <= 1'b1;
          else state_q <= IDLE;
          tx_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Frame payload and its parity bit are captured when the byte leaves the FIFO.
  always_ff @(posedge clk_i) begin
    if (start_frame) begin
      shift_q   <= fifo_rdata;
      par_bit_q <= (^fifo_rdata) ^ ctrl_q[CTRL_PARODD];
    end else if (state_q == DATA && bit_done) begin
      shift_q <= shift_q >> 1;
    end
  end

endmodule
